// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage RV32I pipeline: forwarding, load-use, branch flush, memory wait FSM.
// Optional performance counters are enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1d,
  input  logic [4:0]  rs2d,
  input  logic [4:0]  rs1e,
  input  logic [4:0]  rs2e,
  input  logic [4:0]  rde,
  input  logic [1:0]  result_src_e,
  input  logic        pc_src_e,
  input  logic [4:0]  rdm,
  input  logic        reg_write_m,
  input  logic        mem_req_m,
  input  logic        mem_ready,
  input  logic [4:0]  rdw,
  input  logic        reg_write_w,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  mem_state_t state_r, state_nxt_s;
  logic [7:0] wait_cnt_r, wait_cnt_nxt_s;
  logic       mem_stall_s;
  logic       lw_stall_s;

  // M stage result has priority over W stage result
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Memory wait-state FSM and timeout counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next-state logic; a ready in the first request cycle never leaves IDLE
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      IDLE: begin
        if (mem_req_m && !mem_ready) begin
          state_nxt_s    = WAIT;
          wait_cnt_nxt_s = 8'd1;
        end else begin
          wait_cnt_nxt_s = 8'd0;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = 8'd0;
        end else if (wait_cnt_r == TIMEOUT_VAL) begin
          state_nxt_s = ERR;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end
      end
      ERR: begin
        state_nxt_s = ERR;
      end
      default: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Hazard detection terms
  always_comb begin
    case (state_r)
      IDLE, WAIT: mem_stall_s = mem_req_m && !mem_ready;
      ERR:        mem_stall_s = 1'b1;
      default:    mem_stall_s = 1'b1;
    endcase
    lw_stall_s = (result_src_e == 2'b01) && (rde != 5'd0) &&
                 ((rde == rs1d) || (rde == rs2d));
  end

  assign mem_err = (state_r == ERR);

  // Prioritised stall/flush/forward generation; reset forces bubbles everywhere
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    if (!rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      forward_a_e = fwd_sel(rs1e, rdm, reg_write_m, rdw, reg_write_w);
      forward_b_e = fwd_sel(rs2e, rdm, reg_write_m, rdw, reg_write_w);
      if (mem_stall_s) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall_s) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        flush_w = 1'b0;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic        any_stall_s;
  logic        any_flush_s;

  assign any_stall_s = stall_f | stall_d | stall_e | stall_m;
  assign any_flush_s = flush_d | flush_e;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (any_stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (any_flush_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan steps then randomized cycles against a rule-level model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0]  result_src_e;
  logic        pc_src_e, reg_write_m, mem_req_m, mem_ready, reg_write_w;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // reference model state
  int          m_wait_len = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_stall_cnt = 32'd0;
  logic [31:0] m_flush_cnt = 32'd0;
  logic [3:0]  e_stall;
  logic [2:0]  e_flush;
  logic [1:0]  e_fa, e_fb;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e),
    .rdm(rdm), .reg_write_m(reg_write_m), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .rdw(rdw), .reg_write_w(reg_write_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (reg_write_m && rdm != 5'd0 && rdm == rs) return 2'b10;
    if (reg_write_w && rdw != 5'd0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_outputs();
    bit mstall, lw;
    mstall = m_err || (mem_req_m && !mem_ready);
    lw = (result_src_e == 2'b01) && (rde != 5'd0) && (rde == rs1d || rde == rs2d);
    e_fa = 2'b00;
    e_fb = 2'b00;
    if (!rst) begin
      e_stall = 4'b0000; e_flush = 3'b111;
    end else begin
      e_fa = model_fwd(rs1e);
      e_fb = model_fwd(rs2e);
      if (mstall)        begin e_stall = 4'b1111; e_flush = 3'b001; end
      else if (pc_src_e) begin e_stall = 4'b0000; e_flush = 3'b110; end
      else if (lw)       begin e_stall = 4'b1100; e_flush = 3'b010; end
      else               begin e_stall = 4'b0000; e_flush = 3'b000; end
    end
  endtask

  task automatic model_clock();
    if (!rst) begin
      m_wait_len = 0; m_err = 1'b0; m_stall_cnt = 32'd0; m_flush_cnt = 32'd0;
    end else begin
`ifdef HAZARD_CTRL_PERF_EN
      if (e_stall != 4'b0000 && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
      if (e_flush[2:1] != 2'b00 && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 32'd1;
`endif
      if (!m_err) begin
        if (m_wait_len == 0) begin
          if (mem_req_m && !mem_ready) m_wait_len = 1;
        end else if (mem_ready) begin
          m_wait_len = 0;
        end else if (m_wait_len == TIMEOUT) begin
          m_err = 1'b1;
        end else begin
          m_wait_len++;
        end
      end
    end
  endtask

  // check the current cycle mid-period, then advance the model across the edge
  task automatic cycle();
    #2;
    model_outputs();
    chk("fwd_a", {30'd0, forward_a_e}, {30'd0, e_fa});
    chk("fwd_b", {30'd0, forward_b_e}, {30'd0, e_fb});
    chk("stalls", {28'd0, stall_f, stall_d, stall_e, stall_m}, {28'd0, e_stall});
    chk("flushes", {29'd0, flush_d, flush_e, flush_w}, {29'd0, e_flush});
    chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    chk("stall_cnt", stall_cnt, m_stall_cnt);
    chk("flush_cnt", flush_cnt, m_flush_cnt);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic clear_inputs();
    rs1d = 5'd0; rs2d = 5'd0; rs1e = 5'd0; rs2e = 5'd0; rde = 5'd0; rdm = 5'd0; rdw = 5'd0;
    result_src_e = 2'b00; pc_src_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    mem_req_m = 1'b0; mem_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();

    // forwarding priority
    rdm = 5'd5; rdw = 5'd5; rs1e = 5'd5; reg_write_m = 1'b1; reg_write_w = 1'b1;
    #2 chk("fwd_plan_m", {30'd0, forward_a_e}, 32'd2);
    cycle();
    reg_write_m = 1'b0;
    #2 chk("fwd_plan_w", {30'd0, forward_a_e}, 32'd1);
    cycle();
    rdm = 5'd0; rdw = 5'd0;
    cycle();

    // load-use, then rde = 0
    clear_inputs();
    result_src_e = 2'b01; rde = 5'd3; rs2d = 5'd3;
    #2 chk("lw_plan", {31'd0, stall_f & stall_d & flush_e}, 32'd1);
    cycle();
    rde = 5'd0;
    cycle();

    // branch overrides load-use
    result_src_e = 2'b01; rde = 5'd3; rs2d = 5'd3; pc_src_e = 1'b1;
    #2 chk("br_plan", {30'd0, flush_d & flush_e, stall_f}, 32'd2);
    cycle();
    clear_inputs();

    // memory wait: 3 stalled cycles then release
    mem_req_m = 1'b1; mem_ready = 1'b0;
    repeat (3) cycle();
    mem_ready = 1'b1;
    cycle();
    mem_req_m = 1'b0;
    cycle();

    // timeout into ERR, then reset recovery
    mem_req_m = 1'b1; mem_ready = 1'b0;
    repeat (TIMEOUT + 1) cycle();
    mem_req_m = 1'b0; mem_ready = 1'b1;
    #2 chk("err_plan", {30'd0, mem_err, stall_f}, 32'd3);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    #2 chk("err_clear", {31'd0, mem_err}, 32'd0);
    cycle();

    // perf counters: two load-use stalls and one branch after a fresh reset
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    result_src_e = 2'b01; rde = 5'd7; rs1d = 5'd7;
    cycle();
    clear_inputs();
    cycle();
    result_src_e = 2'b01; rde = 5'd9; rs2d = 5'd9;
    cycle();
    clear_inputs();
    pc_src_e = 1'b1;
    cycle();
    clear_inputs();
    #2;
`ifdef HAZARD_CTRL_PERF_EN
    chk("perf_stall", stall_cnt, 32'd2);
    chk("perf_flush", flush_cnt, 32'd3);
`else
    chk("perf_stall", stall_cnt, 32'd0);
    chk("perf_flush", flush_cnt, 32'd0);
`endif
    cycle();

    // randomized cycles with occasional resets to leave ERR
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 39) != 0);
      rs1d         = 5'($urandom_range(0, 3));
      rs2d         = 5'($urandom_range(0, 3));
      rs1e         = 5'($urandom_range(0, 3));
      rs2e         = 5'($urandom_range(0, 3));
      rde          = 5'($urandom_range(0, 3));
      rdm          = 5'($urandom_range(0, 3));
      rdw          = 5'($urandom_range(0, 3));
      result_src_e = 2'($urandom_range(0, 3));
      pc_src_e     = ($urandom_range(0, 5) == 0);
      reg_write_m  = 1'($urandom_range(0, 1));
      reg_write_w  = 1'($urandom_range(0, 1));
      mem_req_m    = 1'($urandom_range(0, 1));
      mem_ready    = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. It sits beside the F/D/E/M/W pipeline registers and drives their stall/flush enables and the execute-stage forwarding muxes. It resolves RAW hazards, load-use hazards, taken-branch flushes, and data-memory wait states. A wait-state FSM with a timeout freezes the pipeline while data memory is not ready.

## Interface
- MEM_TIMEOUT, 15: max consecutive wait cycles tolerated before entering the error state (1..255)
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- rs1d, rs2d  in  5 each  source registers of the instruction in D
- rs1e, rs2e  in  5 each  source registers of the instruction in E
- rde  in  5  destination register in E
- result_src_e  in  2  result select in E; 2'b01 marks a load
- pc_src_e  in  1  taken branch/jump resolved in E
- rdm  in  5  destination register in M
- reg_write_m  in  1  M instruction writes the register file
- mem_req_m  in  1  M instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- rdw  in  5  destination register in W
- reg_write_w  in  1  W instruction writes the register file
- forward_a_e, forward_b_e  out  2 each  00 = register file, 01 = W result, 10 = M ALU result
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the F/D/E/M pipeline registers
- flush_d, flush_e, flush_w  out  1 each  load a bubble into D/E/W
- mem_err  out  1  sticky memory timeout flag
- stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration)

## Operation
- **Forwarding (combinational)**
  - forward_a_e = 10 if reg_write_m, rdm≠0 and rdm==rs1e.
  - Else forward_a_e = 01 if reg_write_w, rdw≠0 and rdw==rs1e.
  - Else forward_a_e = 00.
  - forward_b_e uses the same rule with rs2e. M has priority over W.
- **Load-use detect:** lw_stall = (result_src_e==01) && rde≠0 && (rde==rs1d || rde==rs2d).
- **Memory FSM states:** IDLE, WAIT, ERR.
  - IDLE → WAIT when mem_req_m && !mem_ready. The wait counter loads 1.
  - WAIT → IDLE when mem_ready. The counter clears.
  - WAIT → ERR when the counter == MEM_TIMEOUT and !mem_ready. Otherwise the counter increments.
  - ERR is absorbing until reset. mem_err = 1 in ERR.
  - mem_stall = (mem_req_m && !mem_ready) in IDLE or WAIT, or 1 in ERR.
- **Priority (highest first):**
  1. mem_stall: stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1, and flush_d = flush_e = 0. A pending branch is held in E and applied after release.
  2. pc_src_e: flush_d = flush_e = 1, and all stalls = 0. This overrides lw_stall, which cannot legally coincide with it.
  3. lw_stall: stall_f = stall_d = 1 and flush_e = 1.
  4. Otherwise all stall/flush outputs = 0.
- **Reset (rst = 0, sampled at posedge):**
  - FSM goes to IDLE, the counter to 0, mem_err to 0, and counters to 0.
  - While rst = 0, outputs are forced: stalls 0, flush_d = flush_e = flush_w = 1, forwards 00.
  - A reset mid-WAIT or in ERR aborts to IDLE.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and current state, with zero latency.
- The FSM and counters update on posedge clk.
- mem_err rises on the clock edge that enters ERR.
- A mem_ready arriving in the first request cycle produces no stall and no state change.
- Release: on the cycle mem_ready = 1 in WAIT, mem_stall = 0 and the pipeline advances on that edge.

## Configuration
- **HAZARD_CTRL_PERF_EN defined:**
  - stall_cnt increments every cycle any stall_* is 1.
  - flush_cnt increments every cycle flush_d or flush_e is 1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- **Not defined:** stall_cnt and flush_cnt are tied to 0 and no counter flops exist.

## Test plan
- **Forwarding:** rdm = rdw = rs1e = 5 with reg_write_m = reg_write_w = 1 → forward_a_e = 10. Clear reg_write_m → 01. Set rdm = rdw = 0 → 00.
- **Load-use:** result_src_e = 01, rde = 3, rs2d = 3 → stall_f = stall_d = flush_e = 1 for one cycle. With rde = 0 → no stall.
- **Branch:** pc_src_e = 1 with the lw_stall pattern also present → flush_d = flush_e = 1 and stall_f = 0.
- **Memory wait:** mem_req_m = 1 with mem_ready low for 3 cycles then high → all stalls and flush_w high for 3 cycles, state returns to IDLE, and mem_err stays 0.
- **Timeout:** MEM_TIMEOUT = 4 with mem_ready held low → ERR entered after 4 WAIT cycles, mem_err = 1 and stalls stay high. A rst = 0 pulse → IDLE and mem_err = 0.
- **Perf counters (macro on):** 2 load-use stalls plus 1 branch → stall_cnt = 2 and flush_cnt = 3.
